// File: rtl/gtp_link_pkg.sv
// Shared 8b/10b link definitions for the GTP TX scheduler and the matching RX deframer.
package gtp_link_pkg;

   localparam logic [7:0] KC_COMMA = 8'hBC;  // K28.5
   localparam logic [7:0] KC_SOF   = 8'hFB;  // K27.7
   localparam logic [7:0] KC_EOF   = 8'hFD;  // K29.7

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_HDR,
      ST_DATA,
      ST_EOF,
      ST_DRAIN
   } state_t;

   // Header byte that follows SOF: upper nibble reserved (zero), lower nibble is the channel.
   typedef struct packed {
      logic [3:0] rsvd;
      logic [3:0] chan;
   } hdr_t;

   function automatic hdr_t make_hdr(input logic [3:0] chan);
      hdr_t h;
      h.rsvd = 4'h0;
      h.chan = chan;
      return h;
   endfunction

endpackage

// File: rtl/gtp_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping to 0.
module gtp_rr_arbiter
   import gtp_link_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0] req_i,
   input  logic [3:0]     ptr_i,
   output logic [3:0]     grant_o,
   output logic           any_req_o
);

   always_comb begin
      grant_o   = 4'd0;
      any_req_o = 1'b0;
      // Walk offsets from far to near so the closest requester to ptr_i wins.
      for (int k = NCH - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr_i) + k) % NCH;
         if (req_i[idx]) begin
            grant_o   = 4'(idx);
            any_req_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gtp_tx_sched.sv
// TX scheduler for one GTP lane: round-robin framing of NCH byte streams with comma insertion.
module gtp_tx_sched
   import gtp_link_pkg::*;
#(
   parameter int         NCH          = 4,
   parameter logic [7:0] COMMA        = gtp_link_pkg::KC_COMMA,
   parameter logic [7:0] K_SOF        = gtp_link_pkg::KC_SOF,
   parameter logic [7:0] K_EOF        = gtp_link_pkg::KC_EOF,
   parameter int         COMMA_PERIOD = 64
) (
   input  logic             gtp_txusrclk,
   input  logic             rst,
   input  logic             gtp_resetdone,
   input  logic             gtp_plllkdet,
   input  logic [NCH*8-1:0] s_data,
   input  logic [NCH-1:0]   s_valid,
   input  logic [NCH-1:0]   s_last,
   output logic [NCH-1:0]   s_ready,
   output logic [NCH-1:0]   frame_abort,
   output logic [7:0]       gtp_txdata,
   output logic             gtp_txcharisk,
   output logic             busy
);

   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

   state_t           state_q, state_d;
   logic [3:0]       grant_q, grant_d;
   logic [3:0]       rr_q, rr_d;
   logic [7:0]       ccnt_q, ccnt_d;
   logic [7:0]       txd_q, txd_d;
   logic             txk_q, txk_d;
   logic [NCH-1:0]   abort_q, abort_d;

   logic             link_ok, comma_due;
   logic [GW-1:0]    gidx;
   logic [3:0]       rr_inc;
   logic [3:0]       arb_grant;
   logic             arb_any;

   assign link_ok   = gtp_resetdone && gtp_plllkdet;
   assign comma_due = (ccnt_q == 8'(COMMA_PERIOD));
   assign gidx      = grant_q[GW-1:0];
   assign rr_inc    = (grant_q == 4'(NCH - 1)) ? 4'd0 : grant_q + 4'd1;

   gtp_rr_arbiter #(.NCH(NCH)) u_arb (
      .req_i     (s_valid),
      .ptr_i     (rr_q),
      .grant_o   (arb_grant),
      .any_req_o (arb_any)
   );

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign s_ready[gi] = (grant_q == 4'(gi)) &&
                           ((state_q == ST_DATA && link_ok && !comma_due) ||
                            (state_q == ST_DRAIN));
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      txd_d   = COMMA;
      txk_d   = 1'b1;
      abort_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (link_ok && arb_any) begin
               grant_d = arb_grant;
               state_d = ST_SOF;
            end
         end
         ST_DRAIN: begin
            if (s_valid[gidx] && s_last[gidx]) begin
               rr_d    = rr_inc;
               state_d = ST_IDLE;
            end
         end
         default: begin
            // Link loss outranks the forced comma; a frame already in EOF just waits for the link.
            if (!link_ok) begin
               if (state_q != ST_EOF) begin
                  abort_d[gidx] = 1'b1;
                  state_d       = ST_DRAIN;
               end
            end else if (!comma_due) begin
               case (state_q)
                  ST_SOF: begin
                     txd_d   = K_SOF;
                     state_d = ST_HDR;
                  end
                  ST_HDR: begin
                     txd_d   = make_hdr(grant_q);
                     txk_d   = 1'b0;
                     state_d = ST_DATA;
                  end
                  ST_DATA: begin
                     if (s_valid[gidx]) begin
                        txd_d = s_data[gidx*8 +: 8];
                        txk_d = 1'b0;
                        if (s_last[gidx]) state_d = ST_EOF;
                     end
                  end
                  ST_EOF: begin
                     txd_d   = K_EOF;
                     rr_d    = rr_inc;
                     state_d = ST_IDLE;
                  end
                  default: ;
               endcase
            end
         end
      endcase

      if (txk_d && txd_d == COMMA) ccnt_d = 8'd0;
      else if (comma_due)          ccnt_d = ccnt_q;
      else                         ccnt_d = ccnt_q + 8'd1;
   end

   always_ff @(posedge gtp_txusrclk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= 4'd0;
         rr_q    <= 4'd0;
         ccnt_q  <= 8'd0;
         txd_q   <= COMMA;
         txk_q   <= 1'b1;
         abort_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         ccnt_q  <= ccnt_d;
         txd_q   <= txd_d;
         txk_q   <= txk_d;
         abort_q <= abort_d;
      end
   end

   assign gtp_txdata    = txd_q;
   assign gtp_txcharisk = txk_q;
   assign frame_abort   = abort_q;
   assign busy          = (state_q != ST_IDLE);

endmodule
